// File: rtl/rete_ctrl.sv
// rete_ctrl: FSM sequencing a two-register A/B datapath to compute GCD(x, y)
// by repeated subtraction. The control lines are decoded combinationally from
// the current state and the comparator status, so RUN behaves as a Mealy
// machine. busy, done and err depend only on the state.
module rete_ctrl #(
  parameter int N       = 8,
  parameter int MAXITER = 255
) (
  input  logic clock,
  input  logic rst_n,
  input  logic start,
  input  logic abort,
  input  logic eq,
  input  logic agtb,
  input  logic a_zero,
  input  logic b_zero,
  output logic mux1,
  output logic mux2,
  output logic wea,
  output logic web,
  output logic aluctl,
  output logic busy,
  output logic done,
  output logic err
);

  // N only describes the datapath that produces the status bits.
  // The counter width is set by MAXITER alone.
  localparam int CW = (N > 0) ? $clog2(MAXITER + 1) : 1;
  localparam logic [CW-1:0] MAXC = CW'(MAXITER);

  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_RUN, S_DONE, S_ERR} state_t;

  state_t          state;
  logic [CW-1:0]   cnt;
  logic            run_sub, sub_a, sub_b;

  // A subtraction happens only in RUN, and only when no higher-priority exit applies.
  always_comb begin
    run_sub = (state == S_RUN) && !abort && !a_zero && !b_zero && !eq && (cnt != MAXC);
    sub_a   = run_sub && agtb;
    sub_b   = run_sub && !agtb;
  end

  // Datapath control and handshake outputs are decoded from state and status.
  always_comb begin
    wea    = (state == S_LOAD) || sub_a;
    web    = (state == S_LOAD) || sub_b;
    mux1   = sub_a;
    mux2   = sub_b;
    aluctl = sub_b;
    busy   = (state == S_LOAD) || (state == S_RUN);
    done   = (state == S_DONE) || (state == S_ERR);
    err    = (state == S_ERR);
  end

  // State and iteration counter. A timeout exits at MAXC, so the counter cannot wrap.
  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
      cnt   <= '0;
    end else begin
      case (state)
        S_IDLE: if (start) state <= S_LOAD;
        S_LOAD: begin
          cnt   <= '0;
          state <= abort ? S_ERR : S_RUN;
        end
        S_RUN: begin
          if (abort || a_zero || b_zero) state <= S_ERR;
          else if (eq)                   state <= S_DONE;
          else if (cnt == MAXC)          state <= S_ERR;
          else                           cnt   <= cnt + 1'b1;
        end
        S_DONE:  state <= S_IDLE;
        S_ERR:   state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_rete_ctrl.sv
// Directed bench for rete_ctrl. A small A/B datapath model closes the loop
// around the controller. Control outputs are sampled 1 ns after each rising
// edge and packed as {wea,web,mux1,mux2,aluctl,busy,done,err}.
module tb_rete_ctrl;

  localparam int MAXITER = 16;

  logic clock = 1'b0;
  logic rst_n, start, abort;
  logic eq, agtb, a_zero, b_zero;
  logic mux1, mux2, wea, web, aluctl, busy, done, err;
  logic [7:0] x, y;
  logic [7:0] ra = 8'd0;
  logic [7:0] rb = 8'd0;
  logic [7:0] alu;
  logic [7:0] ctl;
  int pass_cnt = 0;
  int total    = 0;

  localparam logic [7:0] C_IDLE = 8'b0000_0000;
  localparam logic [7:0] C_LOAD = 8'b1100_0100;
  localparam logic [7:0] C_SUBA = 8'b1010_0100;
  localparam logic [7:0] C_SUBB = 8'b0101_1100;
  localparam logic [7:0] C_RUNH = 8'b0000_0100;
  localparam logic [7:0] C_DONE = 8'b0000_0010;
  localparam logic [7:0] C_ERR  = 8'b0000_0011;

  rete_ctrl #(.N(8), .MAXITER(MAXITER)) dut (
    .clock(clock), .rst_n(rst_n), .start(start), .abort(abort),
    .eq(eq), .agtb(agtb), .a_zero(a_zero), .b_zero(b_zero),
    .mux1(mux1), .mux2(mux2), .wea(wea), .web(web), .aluctl(aluctl),
    .busy(busy), .done(done), .err(err)
  );

  always #5 clock = ~clock;

  // Datapath model: the ALU, the comparators and the two registers.
  assign alu    = aluctl ? (rb - ra) : (ra - rb);
  assign eq     = (ra == rb);
  assign agtb   = (ra > rb);
  assign a_zero = (ra == 8'd0);
  assign b_zero = (rb == 8'd0);
  assign ctl    = {wea, web, mux1, mux2, aluctl, busy, done, err};

  always @(posedge clock) begin
    if (wea) ra <= mux1 ? alu : x;
    if (web) rb <= mux2 ? alu : y;
  end

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  // Drive x and y, then assert start across edge E0. On return we are in cycle 1.
  task automatic launch(input logic [7:0] xv, input logic [7:0] yv);
    x = xv; y = yv; start = 1'b1;
    step();
    start = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; start = 1'b0; abort = 1'b0; x = 8'd0; y = 8'd0;
    #12;
    total++;
    if (ctl !== C_IDLE) $display("FAIL reset_hold ctl=%b expected=%b", ctl, C_IDLE);
    else pass_cnt++;
    @(negedge clock); rst_n = 1'b1;
    step();
    total++;
    if (ctl !== C_IDLE) $display("FAIL reset_idle ctl=%b expected=%b", ctl, C_IDLE);
    else pass_cnt++;
  endtask

  task automatic test_gcd_12_18();
    launch(8'd12, 8'd18);
    total++;
    if (ctl !== C_LOAD) $display("FAIL g1218_c1 ctl=%b expected=%b", ctl, C_LOAD); else pass_cnt++;
    step();
    total++;
    if (ctl !== C_SUBB) $display("FAIL g1218_c2 ctl=%b expected=%b", ctl, C_SUBB); else pass_cnt++;
    step();
    total++;
    if (ctl !== C_SUBA) $display("FAIL g1218_c3 ctl=%b expected=%b", ctl, C_SUBA); else pass_cnt++;
    step();
    total++;
    if (ctl !== C_RUNH) $display("FAIL g1218_c4 ctl=%b expected=%b", ctl, C_RUNH); else pass_cnt++;
    step();
    total++;
    if (ctl !== C_DONE) $display("FAIL g1218_c5 ctl=%b expected=%b", ctl, C_DONE); else pass_cnt++;
    step(); step();
    total++;
    if (ctl !== C_IDLE || {ra, rb} !== 16'h0606)
      $display("FAIL g1218_hold ctl=%b ab=%h expected=%b/0606", ctl, {ra, rb}, C_IDLE);
    else pass_cnt++;
  endtask

  task automatic test_equal();
    launch(8'd7, 8'd7);
    step();
    total++;
    if (ctl !== C_RUNH) $display("FAIL eq77_c2 ctl=%b expected=%b", ctl, C_RUNH); else pass_cnt++;
    step();
    total++;
    if (ctl !== C_DONE) $display("FAIL eq77_c3 ctl=%b expected=%b", ctl, C_DONE); else pass_cnt++;
    step();
    total++;
    if ({ra, rb} !== 16'h0707) $display("FAIL eq77_regs ab=%h expected=0707", {ra, rb}); else pass_cnt++;
  endtask

  task automatic test_zero();
    launch(8'd0, 8'd9);
    step();
    total++;
    if (ctl !== C_RUNH) $display("FAIL zero_c2 ctl=%b expected=%b", ctl, C_RUNH); else pass_cnt++;
    step();
    total++;
    if (ctl !== C_ERR) $display("FAIL zero_c3 ctl=%b expected=%b", ctl, C_ERR); else pass_cnt++;
    step();
    total++;
    if (ctl !== C_IDLE || {ra, rb} !== 16'h0009)
      $display("FAIL zero_after ctl=%b ab=%h expected=%b/0009", ctl, {ra, rb}, C_IDLE);
    else pass_cnt++;
  endtask

  task automatic test_timeout();
    int nb = 0;
    int bad = 0;
    launch(8'd1, 8'd255);
    for (int c = 2; c <= 18; c++) begin
      step();
      if (c == 5) start = 1'b1;
      if (c == 8) start = 1'b0;
      if (ctl === C_SUBB) nb++;
      else if (!(c == 18 && ctl === C_RUNH)) bad++;
    end
    total++;
    if (nb != 16 || bad != 0) $display("FAIL timeout_writes nb=%0d bad=%0d expected=16/0", nb, bad);
    else pass_cnt++;
    step();
    total++;
    if (ctl !== C_ERR) $display("FAIL timeout_c19 ctl=%b expected=%b", ctl, C_ERR); else pass_cnt++;
    start = 1'b1;
    step();
    start = 1'b0;
    total++;
    if (ctl !== C_IDLE || {ra, rb} !== 16'h01ef)
      $display("FAIL timeout_after ctl=%b ab=%h expected=%b/01ef", ctl, {ra, rb}, C_IDLE);
    else pass_cnt++;
  endtask

  task automatic test_abort_run();
    launch(8'd12, 8'd18);
    step();
    step();
    abort = 1'b1;
    #1;
    total++;
    if (ctl !== C_RUNH) $display("FAIL abort_c3 ctl=%b expected=%b", ctl, C_RUNH); else pass_cnt++;
    step();
    abort = 1'b0;
    total++;
    if (ctl !== C_ERR) $display("FAIL abort_c4 ctl=%b expected=%b", ctl, C_ERR); else pass_cnt++;
    step();
    total++;
    if (ctl !== C_IDLE || {ra, rb} !== 16'h0c06)
      $display("FAIL abort_after ctl=%b ab=%h expected=%b/0c06", ctl, {ra, rb}, C_IDLE);
    else pass_cnt++;
  endtask

  task automatic test_abort_load();
    launch(8'd5, 8'd3);
    abort = 1'b1;
    #1;
    total++;
    if (ctl !== C_LOAD) $display("FAIL abortld_c1 ctl=%b expected=%b", ctl, C_LOAD); else pass_cnt++;
    step();
    abort = 1'b0;
    total++;
    if (ctl !== C_ERR || {ra, rb} !== 16'h0503)
      $display("FAIL abortld_c2 ctl=%b ab=%h expected=%b/0503", ctl, {ra, rb}, C_ERR);
    else pass_cnt++;
    step();
  endtask

  task automatic test_back_to_back();
    launch(8'd7, 8'd7);
    step(); step();
    x = 8'd9; y = 8'd6; start = 1'b1;
    step();
    total++;
    if (ctl !== C_IDLE) $display("FAIL b2b_ignore ctl=%b expected=%b", ctl, C_IDLE); else pass_cnt++;
    step();
    start = 1'b0;
    total++;
    if (ctl !== C_LOAD) $display("FAIL b2b_load ctl=%b expected=%b", ctl, C_LOAD); else pass_cnt++;
    step();
    total++;
    if (ctl !== C_SUBA) $display("FAIL b2b_c2 ctl=%b expected=%b", ctl, C_SUBA); else pass_cnt++;
    step();
    total++;
    if (ctl !== C_SUBB) $display("FAIL b2b_c3 ctl=%b expected=%b", ctl, C_SUBB); else pass_cnt++;
    step(); step();
    total++;
    if (ctl !== C_DONE || {ra, rb} !== 16'h0303)
      $display("FAIL b2b_done ctl=%b ab=%h expected=%b/0303", ctl, {ra, rb}, C_DONE);
    else pass_cnt++;
    step();
  endtask

  task automatic test_reset_midrun();
    launch(8'd12, 8'd18);
    step();
    total++;
    if (ctl !== C_SUBB) $display("FAIL rstmid_pre ctl=%b expected=%b", ctl, C_SUBB); else pass_cnt++;
    #2 rst_n = 1'b0;
    #1;
    total++;
    if (ctl !== C_IDLE) $display("FAIL rstmid_async ctl=%b expected=%b", ctl, C_IDLE); else pass_cnt++;
    step(); step();
    #2 rst_n = 1'b1;
    step();
    total++;
    if (ctl !== C_IDLE) $display("FAIL rstmid_idle ctl=%b expected=%b", ctl, C_IDLE); else pass_cnt++;
    launch(8'd7, 8'd7);
    step(); step();
    total++;
    if (ctl !== C_DONE) $display("FAIL rstmid_rerun ctl=%b expected=%b", ctl, C_DONE); else pass_cnt++;
    step();
  endtask

  initial begin
    test_reset();
    test_gcd_12_18();
    test_equal();
    test_zero();
    test_timeout();
    test_abort_run();
    test_abort_load();
    test_back_to_back();
    test_reset_midrun();
    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end

endmodule

// File: doc/rete_ctrl.md
# rete_ctrl

Control unit that sequences the two-register A/B datapath (regA, regB, Sigma next-state network, Omega output network) to compute GCD(x, y) by repeated subtraction. It drives the datapath's mux1, mux2, wea, web and aluctl lines each cycle from its own FSM and from comparator status derived from outA/outB. It also offers a start/done handshake to the surrounding system. The GCD result is left in both A and B when done is asserted.

## Interface
- N, 8: datapath width; sizes nothing internally except documentation of status sources.
- MAXITER, 255: maximum subtraction cycles before abandoning with err; iteration counter width is clog2(MAXITER+1).

- clock  in  1  system clock, rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- start  in  1  request a GCD of the current x, y datapath inputs; sampled only in IDLE.
- abort  in  1  synchronous cancel; honoured in LOAD and RUN.
- eq  in  1  outA == outB (combinational status from datapath).
- agtb  in  1  outA > outB, unsigned.
- a_zero  in  1  outA == 0.
- b_zero  in  1  outB == 0.
- mux1  out  1  newA source: 0 = x input, 1 = ALU result.
- mux2  out  1  newB source: 0 = y input, 1 = ALU result.
- wea  out  1  write enable regA.
- web  out  1  write enable regB.
- aluctl  out  1  ALU op: 0 = A-B, 1 = B-A.
- busy  out  1  high in LOAD and RUN.
- done  out  1  one-cycle pulse at end of operation (success or error).
- err  out  1  valid with done: 1 = zero operand, timeout or abort.

## Operation
- States: IDLE, LOAD, RUN, DONE, ERR.
- IDLE: all control outputs 0, registers hold. start=1 -> LOAD.
- LOAD: mux1=0, mux2=0, wea=1, web=1 (x, y captured at next edge); iteration counter cleared; -> RUN (or -> ERR if abort).
- RUN, evaluated each cycle on current status, priority order:
  - abort -> ERR, no write.
  - a_zero or b_zero -> ERR, no write.
  - eq -> DONE, no write.
  - counter == MAXITER -> ERR, no write.
  - agtb -> wea=1, mux1=1, aluctl=0 (A <= A-B); counter +1; stay.
  - else -> web=1, mux2=1, aluctl=1 (B <= B-A); counter +1; stay.
- DONE: done=1, err=0, no writes; -> IDLE.
- ERR: done=1, err=1, no writes; -> IDLE.
- Never wea and web together except in LOAD; outside LOAD/RUN both 0, so A/B (and Omega out) are stable after completion until the next start.
- Control outputs are combinational decodes of state and status (Mealy in RUN); busy/done/err decode state only.
- start while not IDLE ignored; start in the DONE/ERR cycle ignored (must be re-asserted in IDLE).
- Counter saturates by construction (ERR taken at MAXITER); no wrap.

## Timing
- Reset (rst_n low, any time, any state): state IDLE, counter 0; all outputs 0 immediately (asynchronous). Datapath registers are not reset by this block; an interrupted run leaves them in a partial state.
- start sampled at edge E0 -> LOAD during cycle 1; registers loaded at E1; RUN from cycle 2.
- k = number of subtractions; done pulses in cycle 3+k after E0 for success; busy high cycles 1..2+k.
- Zero operand: err/done in cycle 3.
- Timeout: done/err in cycle 3+MAXITER.
- abort in LOAD at cycle 1: no load occurs? No: LOAD write still happens that cycle (abort affects next state only); ERR in cycle 2.
- Back-to-back: earliest next start sampled in IDLE cycle following DONE/ERR.

## Test plan
- Reset: rst_n low mid-RUN (x=12, y=18) -> all outputs 0 asynchronously, state IDLE; after release, start runs normally.
- x=12, y=18, start -> cycle 2 web=1/aluctl=1 (B=6), cycle 3 wea=1/aluctl=0 (A=6), cycle 4 eq, done=1 err=0 in cycle 5, A=B=6 held.
- x=7, y=7 -> no subtraction writes, done=1 err=0 in cycle 3, A=B=7.
- x=0, y=9 -> done=1 err=1 in cycle 3, no writes after LOAD.
- MAXITER=16, x=1, y=255 -> 16 B-writes, done=1 err=1 in cycle 19; start asserted during busy ignored.
- abort asserted in cycle 3 of x=12, y=18 -> no write that cycle, done=1 err=1 in cycle 4, return to IDLE.
